// File: rtl/parking_lot_ctrl_pkg.sv
// Shared types and width helpers for the parking-lot controller.
//   ent_state_e  : entrance gate / passcode FSM states
//   exit_state_e : exit gate FSM states
//   width_for()  : bits needed to hold 0..max_val
//   max3()       : largest of three values, used to size the shared timers
package parking_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CODE,
    S_ENT_OPEN,
    S_LOCK
  } ent_state_e;

  typedef enum logic {
    X_IDLE,
    X_OPEN
  } exit_state_e;

  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Board-side signal bundle of the parking-lot controller.
//   Prs      : passcode buttons, active-high levels, indexed 1..NUM_BTN
//   Car_in   : entrance sensor level      Car_out : exit sensor level
//   Entrance : entrance gate open         Exit    : exit gate open
//   count    : occupancy                  full/empty : occupancy flags
//   code_err : one-cycle wrong-code pulse locked  : lockout active
// master = board/stimulus side, slave = controller side.
interface parking_lot_ctrl_if #(
  parameter int unsigned NUM_BTN = 3,
  parameter int unsigned CW      = 5
);
  logic [NUM_BTN:1] Prs;
  logic             Car_in;
  logic             Car_out;
  logic             Entrance;
  logic             Exit;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             code_err;
  logic             locked;

  modport master (
    output Prs, Car_in, Car_out,
    input  Entrance, Exit, count, full, empty, code_err, locked
  );

  modport slave (
    input  Prs, Car_in, Car_out,
    output Entrance, Exit, count, full, empty, code_err, locked
  );
endinterface

// File: rtl/parking_lot_ctrl_edge_detect.sv
// Rising-edge detector for a vector of level inputs.
//   CLK, RST : clock, synchronous active-high reset
//   in       : level inputs
//   rise     : high for the cycle in which the matching bit goes 0->1
// The history register always tracks the input, including during reset, so a
// level held through reset does not look like an edge afterwards.
module edge_detect #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge CLK) begin
    if (RST) prev_q <= in;
    else     prev_q <= in;
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: passcode-gated entrance, independent exit gate,
// saturating occupancy count with lockout after repeated wrong codes.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : parking_lot_ctrl_if.slave (buttons, car sensors, gate outputs,
//              count/full/empty, code_err pulse, locked)
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter  int unsigned CAPACITY = 25,
  parameter  int unsigned NUM_BTN  = 3,
  parameter  int unsigned CODE_LEN = 3,
  localparam int unsigned IW       = width_for(NUM_BTN),
  parameter  logic [CODE_LEN*IW-1:0] CODE = {2'd3, 2'd2, 2'd1},
  parameter  int unsigned OPEN_CYCLES = 250,
  parameter  int unsigned EXIT_CYCLES = 100,
  parameter  int unsigned MAX_FAIL    = 3,
  parameter  int unsigned LOCK_CYCLES = 1000
) (
  input logic               CLK,
  input logic               RST,
  parking_lot_ctrl_if.slave bus
);

  localparam int unsigned CW   = width_for(CAPACITY);
  localparam int unsigned TW   = width_for(max3(OPEN_CYCLES, EXIT_CYCLES, LOCK_CYCLES));
  localparam int unsigned FW   = width_for(MAX_FAIL);
  localparam int unsigned IDXW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  // Parameter sanity checks at elaboration.
  if (CAPACITY < 1) begin : g_cap_chk
    $error("parking_lot_ctrl: CAPACITY must be at least 1");
  end
  if (CODE_LEN < 1) begin : g_len_chk
    $error("parking_lot_ctrl: CODE_LEN must be at least 1");
  end

  logic [IW-1:0] code_digits [CODE_LEN];
  for (genvar g = 0; g < CODE_LEN; g++) begin : g_code
    assign code_digits[g] = CODE[g*IW +: IW];
    if ((32'(CODE[g*IW +: IW]) == 0) || (32'(CODE[g*IW +: IW]) > NUM_BTN)) begin : g_bad
      $error("parking_lot_ctrl: CODE digit out of range 1..NUM_BTN");
    end
  end

  // Input edge detection.
  logic [NUM_BTN:1] prs_rise;
  logic [1:0]       car_rise;
  logic             car_in_rise;
  logic             car_out_rise;

  edge_detect #(.WIDTH(NUM_BTN)) u_prs_edge (
    .CLK  (CLK),
    .RST  (RST),
    .in   (bus.Prs),
    .rise (prs_rise)
  );

  edge_detect #(.WIDTH(2)) u_car_edge (
    .CLK  (CLK),
    .RST  (RST),
    .in   ({bus.Car_in, bus.Car_out}),
    .rise (car_rise)
  );

  assign car_in_rise  = car_rise[1];
  assign car_out_rise = car_rise[0];

  // Button index of a single press; simultaneous presses decode to 0, which
  // never matches a code digit.
  logic          press;
  logic [IW-1:0] digit;

  always_comb begin
    digit = '0;
    for (int i = 1; i <= NUM_BTN; i++) begin
      if (prs_rise[i]) digit = IW'(i);
    end
    if (!$onehot(prs_rise)) digit = '0;
  end

  assign press = |prs_rise;

  // Occupancy flags straight from the count register.
  logic [CW-1:0] count_q, count_d;
  logic          is_full, is_empty;

  assign is_full  = (count_q == CW'(CAPACITY));
  assign is_empty = (count_q == '0);

  // Entrance / passcode FSM.
  ent_state_e    state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic          match_q, match_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] ent_timer_q, ent_timer_d;
  logic          code_err_d;
  logic          ent_inc;
  logic          decide;
  logic          match_now;
  logic          entrance_q, code_err_q, locked_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      match_q     <= 1'b0;
      fail_q      <= '0;
      ent_timer_q <= '0;
      entrance_q  <= 1'b0;
      code_err_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      match_q     <= match_d;
      fail_q      <= fail_d;
      ent_timer_q <= ent_timer_d;
      entrance_q  <= (state_d == S_ENT_OPEN);
      code_err_q  <= code_err_d;
      locked_q    <= (state_d == S_LOCK);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    match_d     = match_q;
    fail_d      = fail_q;
    ent_timer_d = ent_timer_q;
    code_err_d  = 1'b0;
    ent_inc     = 1'b0;
    decide      = 1'b0;
    match_now   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press) begin
          match_now   = (digit == code_digits[0]);
          match_d     = match_now;
          idx_d       = IDXW'(1);
          ent_timer_d = '0;
          state_d     = S_CODE;
          decide      = (CODE_LEN == 1);
        end
      end
      S_CODE: begin
        if (press) begin
          match_now   = match_q && (digit == code_digits[idx_q]);
          match_d     = match_now;
          idx_d       = idx_q + 1'b1;
          ent_timer_d = '0;
          decide      = (idx_q == IDXW'(CODE_LEN - 1));
        end else if (ent_timer_q == TW'(OPEN_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          ent_timer_d = ent_timer_q + 1'b1;
        end
      end
      S_ENT_OPEN: begin
        if (car_in_rise) begin
          ent_inc = 1'b1;
          state_d = S_IDLE;
        end else if (ent_timer_q == TW'(OPEN_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          ent_timer_d = ent_timer_q + 1'b1;
        end
      end
      S_LOCK: begin
        if (ent_timer_q == TW'(LOCK_CYCLES - 1)) state_d = S_IDLE;
        else                                     ent_timer_d = ent_timer_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Verdict on the last digit; the full check sees the pre-update count.
    if (decide) begin
      idx_d       = '0;
      ent_timer_d = '0;
      if (match_now) begin
        if (!is_full) begin
          state_d = S_ENT_OPEN;
          fail_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        code_err_d = 1'b1;
        if (fail_q == FW'(MAX_FAIL - 1)) begin
          fail_d  = '0;
          state_d = S_LOCK;
        end else begin
          fail_d  = fail_q + 1'b1;
          state_d = S_IDLE;
        end
      end
    end
  end

  // Exit gate FSM.
  exit_state_e   x_state_q, x_state_d;
  logic [TW-1:0] x_timer_q, x_timer_d;
  logic          ex_dec;
  logic          exit_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_state_q <= X_IDLE;
      x_timer_q <= '0;
      exit_q    <= 1'b0;
    end else begin
      x_state_q <= x_state_d;
      x_timer_q <= x_timer_d;
      exit_q    <= (x_state_d == X_OPEN);
    end
  end

  always_comb begin
    x_state_d = x_state_q;
    x_timer_d = x_timer_q;
    ex_dec    = 1'b0;
    case (x_state_q)
      X_IDLE: begin
        if (car_out_rise && !is_empty) begin
          x_state_d = X_OPEN;
          x_timer_d = '0;
          ex_dec    = 1'b1;
        end
      end
      X_OPEN: begin
        if (x_timer_q == TW'(EXIT_CYCLES - 1)) x_state_d = X_IDLE;
        else                                   x_timer_d = x_timer_q + 1'b1;
      end
      default: x_state_d = X_IDLE;
    endcase
  end

  // Saturating occupancy; simultaneous in and out cancel.
  always_comb begin
    count_d = count_q;
    if (ent_inc && !ex_dec && !is_full)       count_d = count_q + 1'b1;
    else if (ex_dec && !ent_inc && !is_empty) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign bus.Entrance = entrance_q;
  assign bus.Exit     = exit_q;
  assign bus.count    = count_q;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.code_err = code_err_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Self-checking bench for parking_lot_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a deadline-based model.
module tb_parking_lot_ctrl;

  localparam int NB   = 3;
  localparam int CAP  = 2;
  localparam int CW   = 2;
  localparam int CLEN = 3;
  localparam int OPEN = 12;
  localparam int EXIT = 7;
  localparam int LOCK = 30;
  localparam int MAXF = 3;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  parking_lot_ctrl_if #(.NUM_BTN(NB), .CW(CW)) bus ();

  parking_lot_ctrl #(
    .CAPACITY    (CAP),
    .NUM_BTN     (NB),
    .CODE_LEN    (CLEN),
    .OPEN_CYCLES (OPEN),
    .EXIT_CYCLES (EXIT),
    .MAX_FAIL    (MAXF),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cycle    = 0;
  string phase    = "init";

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycle);
  endtask

  // Reference model: remaining-cycle counters and a list of entered digits.
  int code_seq [CLEN] = '{1, 2, 3};
  int m_count, m_gate, m_lock, m_exit, m_fails, m_quiet;
  int m_digits [$];
  bit m_err;
  logic [NB:1] m_prev_prs;
  bit m_prev_cin, m_prev_cout;

  task automatic model_decide();
    bit ok = 1'b1;
    for (int i = 0; i < CLEN; i++) if (m_digits[i] != code_seq[i]) ok = 1'b0;
    m_digits.delete();
    if (ok) begin
      if (m_count < CAP) begin
        m_gate  = OPEN;
        m_fails = 0;
      end
    end else begin
      m_err = 1'b1;
      m_fails++;
      if (m_fails == MAXF) begin
        m_fails = 0;
        m_lock  = LOCK;
      end
    end
  endtask

  task automatic model_step(input bit rst, input logic [NB:1] prs, input bit cin, input bit cout);
    logic [NB:1] rises;
    int digit;
    bit press, cin_r, cout_r, inc, dec;
    m_err = 1'b0;
    if (rst) begin
      m_count = 0; m_gate = 0; m_lock = 0; m_exit = 0; m_fails = 0; m_quiet = 0;
      m_digits.delete();
    end else begin
      rises = prs & ~m_prev_prs;
      press = (rises != '0);
      digit = 0;
      if ($countones(rises) == 1)
        for (int i = 1; i <= NB; i++) if (rises[i]) digit = i;
      cin_r  = cin && !m_prev_cin;
      cout_r = cout && !m_prev_cout;
      inc = 1'b0;
      dec = 1'b0;
      if (m_lock > 0) m_lock--;
      else if (m_gate > 0) begin
        if (cin_r) begin
          inc    = 1'b1;
          m_gate = 0;
        end else m_gate--;
      end else if (press) begin
        m_digits.push_back(digit);
        m_quiet = 0;
        if (m_digits.size() == CLEN) model_decide();
      end else if (m_digits.size() > 0) begin
        m_quiet++;
        if (m_quiet == OPEN) m_digits.delete();
      end
      if (m_exit > 0) m_exit--;
      else if (cout_r && m_count > 0) begin
        m_exit = EXIT;
        dec    = 1'b1;
      end
      if (inc && !dec && m_count < CAP) m_count++;
      else if (dec && !inc && m_count > 0) m_count--;
    end
    m_prev_prs  = prs;
    m_prev_cin  = cin;
    m_prev_cout = cout;
  endtask

  task automatic compare_all();
    check_eq({phase, ".entrance"}, int'(bus.Entrance), int'(m_gate > 0));
    check_eq({phase, ".exit"},     int'(bus.Exit),     int'(m_exit > 0));
    check_eq({phase, ".count"},    int'(bus.count),    m_count);
    check_eq({phase, ".full"},     int'(bus.full),     int'(m_count == CAP));
    check_eq({phase, ".empty"},    int'(bus.empty),    int'(m_count == 0));
    check_eq({phase, ".code_err"}, int'(bus.code_err), int'(m_err));
    check_eq({phase, ".locked"},   int'(bus.locked),   int'(m_lock > 0));
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit rst, input logic [NB:1] prs, input bit cin, input bit cout);
    RST         = rst;
    bus.Prs     = prs;
    bus.Car_in  = cin;
    bus.Car_out = cout;
    @(posedge CLK);
    model_step(rst, prs, cin, cout);
    cycle++;
    @(negedge CLK);
    compare_all();
  endtask

  function automatic logic [NB:1] btn(input int b);
    logic [NB:1] v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Three presses; returns right after the third press so the verdict is visible.
  task automatic enter_code(input int d0, input int d1, input int d2);
    step(1'b0, btn(d0), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, btn(d1), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, btn(d2), 1'b0, 1'b0);
  endtask

  logic [NB:1] r_prs;
  int r, pos;

  initial begin
    RST = 1'b1;
    bus.Prs = '0;
    bus.Car_in = 1'b0;
    bus.Car_out = 1'b0;
    @(negedge CLK);

    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, btn(1), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, btn(1), 1'b0, 1'b0);
    check_eq("rst_count", int'(bus.count), 0);
    check_eq("rst_entrance", int'(bus.Entrance), 0);
    check_eq("rst_empty", int'(bus.empty), 1);
    idle(2);

    phase = "open";
    enter_code(1, 2, 3);
    check_eq("ent_after_3rd", int'(bus.Entrance), 1);
    idle(1);
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("car_in_count", int'(bus.count), 1);
    check_eq("ent_fall", int'(bus.Entrance), 0);
    idle(2);

    phase = "lock";
    for (int k = 0; k < MAXF; k++) begin
      enter_code(1, 3, 2);
      check_eq("bad_code_err", int'(bus.code_err), 1);
      idle(1);
      check_eq("err_one_cycle", int'(bus.code_err), 0);
    end
    check_eq("locked_set", int'(bus.locked), 1);
    enter_code(1, 2, 3);
    check_eq("code_in_lock", int'(bus.Entrance), 0);
    for (int i = 0; i < LOCK + 5 && bus.locked; i++) idle(1);
    check_eq("lock_release", int'(bus.locked), 0);
    idle(2);
    enter_code(1, 2, 3);
    check_eq("open_after_lock", int'(bus.Entrance), 1);

    phase = "timeout";
    idle(OPEN);
    check_eq("gate_timeout", int'(bus.Entrance), 0);
    check_eq("timeout_count", int'(bus.count), 1);
    idle(2);

    phase = "simul";
    enter_code(1, 2, 3);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("simul_count", int'(bus.count), 1);
    check_eq("simul_exit", int'(bus.Exit), 1);
    idle(EXIT + 1);
    check_eq("exit_closed", int'(bus.Exit), 0);

    phase = "fill";
    enter_code(1, 2, 3);
    idle(1);
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("fill_count", int'(bus.count), CAP);
    check_eq("fill_full", int'(bus.full), 1);
    idle(2);
    enter_code(1, 2, 3);
    check_eq("full_refused", int'(bus.Entrance), 0);
    check_eq("full_no_err", int'(bus.code_err), 0);
    idle(2);

    phase = "drain";
    for (int k = CAP; k > 0; k--) begin
      step(1'b0, '0, 1'b0, 1'b1);
      check_eq("drain_count", int'(bus.count), k - 1);
      idle(EXIT + 1);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("empty_exit_ignored", int'(bus.Exit), 0);
    check_eq("empty_count", int'(bus.count), 0);
    idle(2);

    phase = "random";
    pos = 0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        r_prs = btn(code_seq[pos]);
        pos = (pos + 1) % CLEN;
      end else if (r < 40) r_prs = btn($urandom_range(1, NB));
      else if (r < 43)     r_prs = '1;
      else                 r_prs = '0;
      step(($urandom_range(0, 499) == 0), r_prs,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
